serial_mult_seq: RTL

Parametrised, multi-cycle successor to the team's 8-bit serial multiplier. Two operands arrive serially on one `idata` bus with a `put`/`ready` handshake. The product is computed by a radix-2 shift-add datapath over `WIDTH` cycles. The result is held until the consumer acknowledges it with `get`. An optional two's-complement mode is provided, as is a synchronous abort. The block sits between an operand producer and a result consumer that both use the team's put/get handshake convention.

---
 rtl/serial_mult_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/serial_mult_seq.sv
// Serial radix-2 shift-add multiplier with put/get handshake, optional
// two's-complement mode and synchronous abort.
module serial_mult_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 clr,
    input  logic                 put,
    input  logic [WIDTH-1:0]     idata,
    input  logic                 get,
    output logic                 ready,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_valid
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + 1;
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W4B  = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [AW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;
    logic              sign_q;
    logic [PW-1:0]     result_q;

    logic              ready_d;
    logic              busy_d;
    logic              valid_d;
    logic              ready_q;
    logic              busy_q;
    logic              valid_q;

    logic              a_accept;
    logic              b_accept;
    logic              last_iter;
    logic [WIDTH:0]    sum_hi;
    logic [AW-1:0]     acc_sh;
    logic [PW-1:0]     prod;
    logic [PW-1:0]     prod_fin;
    logic              op_msb;

    // Magnitude of an operand; identity in unsigned mode.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        if ((SIGNED != 0) && v[WIDTH-1]) begin
            mag = ~v + WIDTH'(1);
        end else begin
            mag = v;
        end
    endfunction

    assign a_accept  = (state_q == IDLE) && put;
    assign b_accept  = (state_q == W4B) && put;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign op_msb    = (SIGNED != 0) && idata[WIDTH-1];

    // One shift-add step: conditional add into the upper half, then shift right.
    always_comb begin
        sum_hi   = acc_q[AW-1:WIDTH] + {1'b0, mcand_q & {WIDTH{mplier_q[0]}}};
        acc_sh   = {1'b0, sum_hi, acc_q[WIDTH-1:1]};
        prod     = acc_sh[PW-1:0];
        prod_fin = sign_q ? (~prod + PW'(1)) : prod;
    end

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clr overrides everything
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (put)       state_d = W4B;
                W4B:     if (put)       state_d = CALC;
                CALC:    if (last_iter) state_d = DONE;
                DONE:    if (get)       state_d = IDLE;
                default:                state_d = IDLE;
            endcase
        end
    end

    // Output decode from the next state so the flags come straight from flops
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        case (state_d)
            IDLE:    ready_d = 1'b1;
            W4B:     ready_d = 1'b1;
            CALC:    busy_d  = 1'b1;
            DONE:    valid_d = 1'b1;
            default: ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else if (clr) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else if (a_accept) begin
            mcand_q  <= mag(idata);
            sign_q   <= op_msb;
        end else if (b_accept) begin
            mplier_q <= mag(idata);
            sign_q   <= sign_q ^ op_msb;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == CALC) begin
            acc_q    <= acc_sh;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last_iter) begin
                result_q <= prod_fin;
            end
        end
    end

    assign ready        = ready_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q & {PW{valid_q}};

endmodule
